mc_ctrl: RTL

Multi-cycle control unit for the RV32I core: a parametrised successor to the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a ready/valid memory handshake with a configurable timeout. It traps on illegal encodings or memory timeouts and counts retired instructions. It sits between the instruction register (source of Op/Funct7/Funct3) and the datapath muxes, PC register, register file and memory port.

---
 rtl/ctrl_pkg.sv | 97 +++++++++
 rtl/rv32i_decode.sv | 105 ++++++++++
 rtl/mc_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV32I control unit.
//   state_t    FSM state encoding (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//   class_t    instruction class used by the FSM to pick its path
//   ALU_*      ALUOp codes shared with the datapath ALU
//   EXT_*      one-hot immediate select {SHAMT, I, S, B, U, J}
//   NPC_*      next-PC select, WD_* register write-back select
//   OP_*/F7_*  opcode and funct7 values, TRAP_* trap cause codes
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5
    } class_t;

    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_BNE  = 5'b00101;
    localparam logic [4:0] ALU_BLT  = 5'b00110;
    localparam logic [4:0] ALU_BGE  = 5'b00111;
    localparam logic [4:0] ALU_BLTU = 5'b01000;
    localparam logic [4:0] ALU_BGEU = 5'b01001;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;
    localparam logic [4:0] ALU_SLL  = 5'b01111;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b10001;

    localparam logic [5:0] EXT_NONE  = 6'b000000;
    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IFETCH  = 2'b10;
    localparam logic [1:0] TRAP_DATA    = 2'b11;

    // Funct3 -> ALU operation for the R-type / OP-IMM group. 'alt' selects
    // sub over add and sra over srl (funct7 = 0100000).
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decode.sv
// rv32i_decode: combinational RV32I instruction decoder.
//   i_op, i_funct7, i_funct3  instruction register fields
//   o_legal                   encoding is in the supported RV32I subset
//   o_class                   instruction class for the sequencing FSM
//   o_alu_op, o_ext_op        ALU operation and one-hot immediate select
//   o_alu_src                 ALU B operand comes from the immediate
module rv32i_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    input  logic [6:0] i_funct7,
    input  logic [2:0] i_funct3,
    output logic       o_legal,
    output class_t     o_class,
    output logic [4:0] o_alu_op,
    output logic [5:0] o_ext_op,
    output logic       o_alu_src
);

    logic w_f7_base;
    logic w_f7_alt;
    logic w_is_shift;

    assign w_f7_base  = (i_funct7 == F7_BASE);
    assign w_f7_alt   = (i_funct7 == F7_ALT);
    assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    always_comb begin
        o_legal   = 1'b0;
        o_class   = CLS_ALU;
        o_alu_op  = ALU_NOP;
        o_ext_op  = EXT_NONE;
        o_alu_src = 1'b0;
        case (i_op)
            OP_R: begin
                // Only add/sub and srl/sra have an alternate funct7 form.
                o_legal  = w_f7_base ||
                           (w_f7_alt && ((i_funct3 == 3'b000) || (i_funct3 == 3'b101)));
                o_alu_op = alu_from_f3(i_funct3, w_f7_alt);
            end
            OP_IMM: begin
                o_alu_src = 1'b1;
                if (w_is_shift) begin
                    // slli needs funct7 = 0; srli/srai accept the two shift forms.
                    o_legal  = w_f7_base || (w_f7_alt && (i_funct3 == 3'b101));
                    o_ext_op = EXT_SHAMT;
                    o_alu_op = alu_from_f3(i_funct3, w_f7_alt);
                end else begin
                    // funct7 bits are immediate bits here, never checked.
                    o_legal  = 1'b1;
                    o_ext_op = EXT_I;
                    o_alu_op = alu_from_f3(i_funct3, 1'b0);
                end
            end
            OP_LOAD: begin
                o_legal   = (i_funct3 == 3'b010);
                o_class   = CLS_LOAD;
                o_alu_op  = ALU_ADD;
                o_ext_op  = EXT_I;
                o_alu_src = 1'b1;
            end
            OP_STORE: begin
                o_legal   = (i_funct3 == 3'b010);
                o_class   = CLS_STORE;
                o_alu_op  = ALU_ADD;
                o_ext_op  = EXT_S;
                o_alu_src = 1'b1;
            end
            OP_BRANCH: begin
                o_class  = CLS_BRANCH;
                o_ext_op = EXT_B;
                o_legal  = 1'b1;
                case (i_funct3)
                    3'b000:  o_alu_op = ALU_SUB;
                    3'b001:  o_alu_op = ALU_BNE;
                    3'b100:  o_alu_op = ALU_BLT;
                    3'b101:  o_alu_op = ALU_BGE;
                    3'b110:  o_alu_op = ALU_BLTU;
                    3'b111:  o_alu_op = ALU_BGEU;
                    default: o_legal  = 1'b0;
                endcase
            end
            OP_JAL: begin
                o_legal  = 1'b1;
                o_class  = CLS_JAL;
                o_ext_op = EXT_J;
            end
            OP_JALR: begin
                o_legal   = (i_funct3 == 3'b000);
                o_class   = CLS_JALR;
                o_alu_op  = ALU_ADD;
                o_ext_op  = EXT_I;
                o_alu_src = 1'b1;
            end
            OP_LUI: begin
                o_legal   = 1'b1;
                o_alu_op  = ALU_LUI;
                o_ext_op  = EXT_U;
                o_alu_src = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, waits on a ready/valid memory port with
// a timeout, traps on illegal encodings or timeouts, counts retirements.
//   clk, rstn                    clock, synchronous active-low reset
//   Op, Funct7, Funct3, Zero     IR fields and ALU branch flag
//   mem_ready / mem_req, mem_we  memory handshake
//   IRWrite, PCWrite, RegWrite   one-cycle datapath strobes
//   ALUSrc, EXTOp, ALUOp         ALU operand/operation controls
//   NPCOp, WDSel                 next-PC and write-back selects
//   trap, trap_cause             halted flag and cause
//   instret                      retired-instruction counter (CNT_W bits)
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [5:0]       EXTOp,
    output logic [4:0]       ALUOp,
    output logic [2:0]       NPCOp,
    output logic [1:0]       WDSel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    // Wide enough to hold MEM_TIMEOUT-1 and saturate above it.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM =
        WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_instret;

    logic             w_legal;
    class_t           w_class;
    logic [4:0]       w_alu_op;
    logic [5:0]       w_ext_op;
    logic             w_alu_src;
    logic             w_timeout;
    logic             w_retire;
    logic [1:0]       w_trap_code;

    rv32i_decode u_decode (
        .i_op      (Op),
        .i_funct7  (Funct7),
        .i_funct3  (Funct3),
        .o_legal   (w_legal),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_ext_op  (w_ext_op),
        .o_alu_src (w_alu_src)
    );

    // This cycle is the MEM_TIMEOUT-th consecutive wait; a ready in the same
    // cycle takes priority in the FSM below.
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LIM) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_cause   <= TRAP_NONE;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready &&
                         (r_wait != '1)) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_trap_code != TRAP_NONE) begin
                r_cause <= w_trap_code;
            end
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_trap_code = TRAP_NONE;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc      = 1'b0;
        EXTOp       = EXT_NONE;
        ALUOp       = ALU_NOP;
        NPCOp       = NPC_PLUS4;
        WDSel       = WD_ALU;
        trap        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_trap_code = TRAP_IFETCH;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next      = S_TRAP;
                    w_trap_code = TRAP_ILLEGAL;
                end
            end
            S_EXEC: begin
                ALUOp  = w_alu_op;
                ALUSrc = w_alu_src;
                EXTOp  = w_ext_op;
                case (w_class)
                    CLS_BRANCH: begin
                        PCWrite  = Zero;
                        NPCOp    = NPC_BRANCH;
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: w_next = S_MEM;
                    default:             w_next = S_WB;
                endcase
            end
            S_MEM: begin
                // ALU controls stay up so the address is stable for the access.
                mem_req = 1'b1;
                mem_we  = (w_class == CLS_STORE);
                ALUOp   = w_alu_op;
                ALUSrc  = w_alu_src;
                EXTOp   = w_ext_op;
                if (mem_ready) begin
                    if (w_class == CLS_STORE) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_trap_code = TRAP_DATA;
                end
            end
            S_WB: begin
                // No ALU result register: the ALU keeps computing through WB.
                RegWrite = 1'b1;
                ALUOp    = w_alu_op;
                ALUSrc   = w_alu_src;
                EXTOp    = w_ext_op;
                case (w_class)
                    CLS_LOAD: WDSel = WD_MEM;
                    CLS_JAL: begin
                        WDSel   = WD_PC;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JUMP;
                    end
                    CLS_JALR: begin
                        WDSel   = WD_PC;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JALR;
                    end
                    default: WDSel = WD_ALU;
                endcase
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign trap_cause = r_cause;
    assign instret    = r_instret;

endmodule
